// File: rtl/bit_serializer_if.sv
// Upstream word handshake for the bit serializer.
// Carries one WIDTH-bit parallel word with a valid/ready pair.
//   din        : parallel word offered by the producer
//   din_valid  : producer has a word on din
//   din_ready  : serializer can take a word this cycle
// The master modport is the word producer; the slave modport is the serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage that feeds the serial sequence detector's x input.
// Words arrive over a valid/ready handshake. One word can wait in a hold
// buffer while another is being shifted, so back-to-back words come out
// with no idle gap. When no word is in flight, x sits at IDLE_BIT.
// Ports:
//   clk      : clock, all state changes on the rising edge
//   reset    : synchronous, active-low reset
//   up       : word handshake (din, din_valid in; din_ready out)
//   x        : serial data bit
//   x_valid  : x carries a data bit this cycle
//   sof      : x is the first bit of a word
//   busy     : shift engine active or hold buffer occupied
//   done_cnt : number of fully shifted words, wraps 255 -> 0
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit IDLE_BIT  = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    bit_serializer_if.slave     up,
    output logic                x,
    output logic                x_valid,
    output logic                sof,
    output logic                busy,
    output logic [7:0]          done_cnt
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   shiftReg_q, shiftReg_d;
    logic [WIDTH-1:0]   hold_q,     hold_d;
    logic               holdFull_q, holdFull_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [7:0]         doneCnt_q,  doneCnt_d;
    logic               sof_q,      sof_d;

    logic               lastBit;
    logic               accept;
    logic               curBit;
    logic [WIDTH-1:0]   shifted;

    // Ready depends only on reset and the hold flag, never on the engine,
    // so the upstream sees no combinational path through the shifter.
    assign up.din_ready = reset & ~holdFull_q;
    assign accept       = up.din_valid & up.din_ready;
    assign lastBit      = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    assign curBit  = MSB_FIRST ? shiftReg_q[WIDTH-1] : shiftReg_q[0];
    assign shifted = MSB_FIRST ? {shiftReg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shiftReg_q[WIDTH-1:1]};

    // Serial outputs come straight from registers only.
    assign x_valid  = (state_q == SHIFT);
    assign x        = (state_q == SHIFT) ? curBit : IDLE_BIT;
    assign sof      = sof_q;
    assign busy     = (state_q == SHIFT) | holdFull_q;
    assign done_cnt = doneCnt_q;

    // Load decision. A word boundary (idle engine or last bit) prefers the
    // held word, then a bypass of din; mid-word, a new word lands in hold
    // while the shifter keeps going.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        hold_d     = hold_q;
        holdFull_d = holdFull_q;
        cnt_d      = cnt_q;
        sof_d      = 1'b0;
        doneCnt_d  = lastBit ? doneCnt_q + 8'd1 : doneCnt_q;

        if ((state_q == IDLE) || lastBit) begin
            cnt_d = '0;
            if (holdFull_q) begin
                shiftReg_d = hold_q;
                holdFull_d = 1'b0;
                state_d    = SHIFT;
                sof_d      = 1'b1;
            end else if (accept) begin
                shiftReg_d = up.din;
                state_d    = SHIFT;
                sof_d      = 1'b1;
            end else begin
                state_d    = IDLE;
            end
        end else begin
            if (accept) begin
                hold_d     = up.din;
                holdFull_d = 1'b1;
            end
            shiftReg_d = shifted;
            cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous active-low reset; reset drops both the
    // word in flight and the held word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            hold_q     <= '0;
            holdFull_q <= 1'b0;
            cnt_q      <= '0;
            doneCnt_q  <= 8'd0;
            sof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            hold_q     <= hold_d;
            holdFull_q <= holdFull_d;
            cnt_q      <= cnt_d;
            doneCnt_q  <= doneCnt_d;
            sof_q      <= sof_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer. Two instances share one stimulus stream:
// dut0 uses the defaults (MSB first, idle level 0) and dut1 sends LSB first
// with idle level 1. A word-queue reference model predicts every output in
// every cycle.
module tb_bit_serializer;

    localparam int W = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;

    logic       x0, xValid0, sof0, busy0;
    logic [7:0] done0;
    logic       x1, xValid1, sof1, busy1;
    logic [7:0] done1;

    int         checks = 0;
    int         errors = 0;

    // Reference model: words accepted but not fully sent, the index of the
    // bit being shown this cycle, and the completed-word count.
    logic [W-1:0] wordQ[$];
    int           bitPos    = 0;
    logic [7:0]   doneModel = 8'd0;

    bit_serializer_if #(.WIDTH(W)) if0 ();
    bit_serializer_if #(.WIDTH(W)) if1 ();

    bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0), .MSB_FIRST(1'b1)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .up       (if0.slave),
        .x        (x0),
        .x_valid  (xValid0),
        .sof      (sof0),
        .busy     (busy0),
        .done_cnt (done0)
    );

    bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1), .MSB_FIRST(1'b0)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .up       (if1.slave),
        .x        (x1),
        .x_valid  (xValid1),
        .sof      (sof1),
        .busy     (busy1),
        .done_cnt (done1)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // One comparison: counts it, and on a difference counts and reports it.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare all
    // outputs of both instances with the model, then advance the model to
    // reflect the coming rising edge.
    task automatic applyStimulus(input logic rst, input logic valid,
                                 input logic [W-1:0] data, output logic accepted);
        logic expValid, expHold, expReady, expSof, expBit0, expBit1;
        @(negedge clk);
        reset         = rst;
        if0.din       = data;
        if0.din_valid = valid;
        if1.din       = data;
        if1.din_valid = valid;
        #1;
        expValid = (wordQ.size() > 0);
        expHold  = (wordQ.size() > 1);
        expSof   = expValid && (bitPos == 0);
        expBit0  = expValid ? wordQ[0][W-1-bitPos] : 1'b0;
        expBit1  = expValid ? wordQ[0][bitPos]     : 1'b1;
        expReady = rst && !expHold;

        checkOutput("x_msb",        {7'd0, x0},            {7'd0, expBit0});
        checkOutput("x_valid_msb",  {7'd0, xValid0},       {7'd0, expValid});
        checkOutput("sof_msb",      {7'd0, sof0},          {7'd0, expSof});
        checkOutput("busy_msb",     {7'd0, busy0},         {7'd0, expValid | expHold});
        checkOutput("ready_msb",    {7'd0, if0.din_ready}, {7'd0, expReady});
        checkOutput("done_cnt_msb", done0,                 doneModel);
        checkOutput("x_lsb",        {7'd0, x1},            {7'd0, expBit1});
        checkOutput("x_valid_lsb",  {7'd0, xValid1},       {7'd0, expValid});
        checkOutput("sof_lsb",      {7'd0, sof1},          {7'd0, expSof});
        checkOutput("busy_lsb",     {7'd0, busy1},         {7'd0, expValid | expHold});
        checkOutput("ready_lsb",    {7'd0, if1.din_ready}, {7'd0, expReady});
        checkOutput("done_cnt_lsb", done1,                 doneModel);

        accepted = expReady && valid;
        if (!rst) begin
            wordQ.delete();
            bitPos    = 0;
            doneModel = 8'd0;
        end else begin
            if (expValid) begin
                if (bitPos == W - 1) begin
                    void'(wordQ.pop_front());
                    bitPos    = 0;
                    doneModel = doneModel + 8'd1;
                end else begin
                    bitPos++;
                end
            end
            if (accepted) wordQ.push_back(data);
        end
    endtask

    // Offer a word with valid held high until it is taken, within a bound.
    task automatic sendWord(input logic [W-1:0] data);
        logic acc;
        logic taken;
        taken = 1'b0;
        for (int t = 0; t < 64 && !taken; t++) begin
            applyStimulus(1'b1, 1'b1, data, acc);
            taken = acc;
        end
        checks++;
        assert (taken) else begin
            errors++;
            $error("[TB] FAIL accept_timeout: observed not accepted expected accepted for %0h", data);
        end
    endtask

    task automatic idleCycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, W'($urandom), acc);
    endtask

    // Directed sequence: reset with valid high, single word, back-to-back
    // pair, reset mid-word, random gaps, then a 257-word stream for wrap.
    initial begin
        logic acc;
        if0.din       = 8'hA5;
        if0.din_valid = 1'b1;
        if1.din       = 8'hA5;
        if1.din_valid = 1'b1;

        applyStimulus(1'b0, 1'b1, 8'hA5, acc);
        applyStimulus(1'b0, 1'b1, 8'hA5, acc);
        idleCycles(3);

        sendWord(8'hA5);
        idleCycles(10);
        checkOutput("single_done", done0, 8'd1);

        sendWord(8'hA0);
        sendWord(8'h0F);
        idleCycles(20);
        checkOutput("pair_done", done0, 8'd3);

        sendWord(8'hFF);
        sendWord(8'h55);
        idleCycles(2);
        applyStimulus(1'b0, 1'b0, 8'h00, acc);
        idleCycles(12);
        checkOutput("midreset_done", done0, 8'd0);
        checkOutput("midreset_x_lsb", {7'd0, x1}, 8'd1);

        for (int i = 0; i < 40; i++) begin
            idleCycles($urandom_range(0, 2));
            sendWord(W'($urandom));
        end
        idleCycles(20);
        checkOutput("random_done", done1, 8'd40);

        applyStimulus(1'b0, 1'b0, 8'h00, acc);
        for (int i = 0; i < 257; i++) sendWord(W'($urandom));
        idleCycles(20);
        checkOutput("wrap_done_msb", done0, 8'd1);
        checkOutput("wrap_done_lsb", done1, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends on its own.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage feeding the serial sequence detector's `x` input.
- Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts them out one bit per clock.
- Back-to-back words leave no idle gap.
- When no word is in flight, the serial line holds a defined idle level so the detector sees a clean stream.

Parameters:
- WIDTH, 8, word width in bits (≥2).
- IDLE_BIT, 0, level driven on x when no bit is valid.
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- din  in  WIDTH  parallel word.
- din_valid  in  1  din holds a word to transfer.
- din_ready  out  1  block can accept a word this cycle.
- x  out  1  serial bit; connects to the detector's x.
- x_valid  out  1  x carries a data bit this cycle.
- sof  out  1  x is the first bit of a word.
- busy  out  1  shift engine active or hold buffer full.
- done_cnt  out  8  count of fully shifted words, wraps 255→0.

Behaviour:
- Reset is sampled on clk; reset=0 at an edge gives the reset state after that edge.
  - Engine IDLE, shreg=0, bit counter cnt=0, hold_full=0, done_cnt=0.
  - x=IDLE_BIT, x_valid=0, sof=0, busy=0.
- din_ready = reset & ~hold_full, combinational; it has no combinational path from the engine state.
- Accept: din_valid & din_ready at an edge. A word not accepted stays pending; the upstream holds din stable.
- Engine states:
  - IDLE: x_valid=0, x=IDLE_BIT.
  - SHIFT: x_valid=1, x=current bit of shreg.
  - Bit order: with MSB_FIRST=1, shreg[WIDTH-1] goes out first and shreg shifts left. With MSB_FIRST=0, shreg[0] goes out first and shreg shifts right.
- cnt counts bits sent in the current word, 0..WIDTH-1. last = SHIFT & (cnt==WIDTH-1).
- Load decision at each edge, priority order:
  1. IDLE or last, with hold_full=1: load shreg from hold, clear hold_full, cnt=0, go to/stay in SHIFT. A simultaneous accept is impossible because din_ready=0.
  2. IDLE or last, with hold_full=0 and accept: bypass, loading din directly into shreg, cnt=0, SHIFT.
  3. Engine busy (SHIFT and not last) and accept: write din into hold, set hold_full.
  4. last, no word available: go to IDLE, cnt=0.
  5. SHIFT, not last: shift shreg, cnt+1.
- Latency: a word accepted into an idle, empty block has its first bit on x in the cycle after the accept edge.
- Back-to-back: a WIDTH-bit word occupies exactly WIDTH consecutive x_valid cycles. A following word already in hold starts the very next cycle with no gap.
- sof=1 exactly in the first cycle of each word, i.e. after any load edge.
- done_cnt increments by 1 at every edge where last is true. 8-bit wrap.
- busy = (state==SHIFT) | hold_full.
- Reset mid-word: the word in flight and the hold content are discarded, with no partial completion. The next cycle shows x=IDLE_BIT, x_valid=0, and done_cnt=0.
- Reset asserted with din_valid=1: no accept, because din_ready=0.
- x, x_valid and sof are registered or derived only from registers; there is no combinational path from din or din_valid to x.

Test Plan:
- Reset: hold reset low 2 cycles with din_valid=1 → din_ready=0, x=0, x_valid=0, sof=0, busy=0, done_cnt=0; no word accepted after release until din_valid is sampled with din_ready=1.
- Single word: accept 8'hA5 at edge 0 → cycles 1..8 give x_valid=1 and x=1,0,1,0,0,1,0,1; sof=1 only in cycle 1; cycle 9 gives x=0, x_valid=0, busy=0, done_cnt=1. Detector downstream sees the 1,0,1,0 prefix and asserts z.
- Back-to-back: din_valid held high with 8'hA0 then 8'h0F → 16 consecutive x_valid cycles with bits 10100000 00001111; sof in cycles 1 and 9; din_ready=0 while hold_full; done_cnt=2 at end.
- Reset mid-word: accept 8'hFF, queue 8'h55 into hold, pull reset low during bit 3 → next cycle x_valid=0, x=0, hold_full=0, done_cnt=0; 8'h55 is never emitted.
- MSB_FIRST=0, IDLE_BIT=1: accept 8'h01 → x=1,0,0,0,0,0,0,0; x=1 in idle cycles before and after.
- Wrap: stream 256 words back-to-back → done_cnt returns to 0 and then reads 1 after the 257th word, with no gaps in x_valid.
